// File: rtl/kbd_pkg.sv
// Shared constants, key map and state encoding for the keypad scanner.
package kbd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int CODE_W   = 4;
    localparam int HIT_W    = $clog2(NUM_KEYS + 1);

    // Indexed by row*4+col; rows top to bottom, columns left to right.
    localparam logic [NUM_KEYS-1:0][CODE_W-1:0] KEY_MAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD
    } kbd_state_e;

    // The snapshot is stored column-major (col*4+row); the key map is row-major.
    function automatic int unsigned snap_to_key(input int unsigned snap_idx);
        return (snap_idx % NUM_ROWS) * NUM_COLS + snap_idx / NUM_ROWS;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
module row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_row,
    output logic [3:0] o_row
);
    logic [3:0] r_meta;
    logic [3:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 4'b1111;
            r_sync <= 4'b1111;
        end else begin
            r_meta <= i_row;
            r_sync <= r_meta;
        end
    end

    assign o_row = r_sync;

endmodule

// File: rtl/keypad_hex_scanner.sv
// 4x4 keypad scanner: column scan, whole-scan debounce, hex decode and 16-bit digit entry.
module keypad_hex_scanner
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV_BITS  = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    input  logic                clr,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_down,
    output logic [15:0]         value
);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    logic [3:0]               w_row_s;
    logic [SCAN_DIV_BITS-1:0] r_dwell;
    logic [1:0]               r_col_sel;
    logic [15:0]              r_snap;
    logic [15:0]              w_snap_now;
    logic                     w_tc;
    logic                     w_scan_end;
    logic [HIT_W-1:0]         w_hits;
    logic [CODE_W-1:0]        w_cand;
    logic                     w_cand_ok;
    logic                     w_any;
    kbd_state_e               r_state;
    kbd_state_e               w_state_next;
    logic                     w_accept;
    logic [3:0]               r_cnt;
    logic [CODE_W-1:0]        r_cand;
    logic                     r_key_valid;
    logic [CODE_W-1:0]        r_key_code;
    logic [15:0]              r_value;

    row_sync u_row_sync (
        .clk   (clk),
        .rst   (rst),
        .i_row (row),
        .o_row (w_row_s)
    );

    assign w_tc       = &r_dwell;
    assign w_scan_end = w_tc && (r_col_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwell   <= '0;
            r_col_sel <= '0;
            r_snap    <= '0;
        end else begin
            r_dwell <= r_dwell + 1'b1;
            if (w_tc) begin
                r_snap[{r_col_sel, 2'b00} +: 4] <= ~w_row_s;
                r_col_sel                       <= r_col_sel + 2'd1;
            end
        end
    end

    // The last column is merged combinationally so scan end evaluates that cycle's rows.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_snap_now                          = r_snap;
        w_snap_now[{r_col_sel, 2'b00} +: 4] = ~w_row_s;
        w_hits                              = '0;
        w_cand                              = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_snap_now[i]) begin
                w_hits = w_hits + 1'b1;
                w_cand = KEY_MAP[snap_to_key(i)];
            end
        end
    end

    assign w_cand_ok = (w_hits == HIT_W'(1));
    assign w_any     = |w_snap_now;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (w_scan_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cand_ok) begin
                        if (DB_N == 4'd1) begin
                            w_state_next = ST_HELD;
                            w_accept     = 1'b1;
                        end else begin
                            w_state_next = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_cand_ok) begin
                        w_state_next = ST_IDLE;
                    end else if (w_cand == r_cand && (r_cnt + 4'd1) == DB_N) begin
                        w_state_next = ST_HELD;
                        w_accept     = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!w_any && (r_cnt + 4'd1) == DB_N) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // r_cnt counts matching scans while debouncing and empty scans while held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_value     <= '0;
        end else begin
            r_key_valid <= w_accept;
            if (w_scan_end) begin
                if (w_accept) begin
                    r_cnt <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE:     r_cnt <= w_cand_ok ? 4'd1 : 4'd0;
                        ST_DEBOUNCE: r_cnt <= !w_cand_ok        ? 4'd0 :
                                              (w_cand == r_cand) ? r_cnt + 4'd1 : 4'd1;
                        ST_HELD:     r_cnt <= (w_any || w_state_next == ST_IDLE) ? 4'd0 : r_cnt + 4'd1;
                        default:     r_cnt <= '0;
                    endcase
                end
                if (r_state != ST_HELD && w_cand_ok) r_cand <= w_cand;
            end
            if (w_accept) r_key_code <= w_cand;
            if (clr)           r_value <= '0;
            else if (w_accept) r_value <= {r_value[11:0], w_cand};
        end
    end

    always_comb begin
        key_down = (r_state == ST_HELD);
        col      = ~(4'b0001 << r_col_sel);
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign value     = r_value;

endmodule

// File: tb/tb_keypad_hex_scanner.sv
// Self-checking bench: a modelled keypad drives the scanner; a scan-level history model predicts accepts.
module tb_keypad_hex_scanner;

    localparam int N     = 3;
    localparam int SCANC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clr;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic [15:0] value;

    logic [15:0] pressed;
    bit          clr_tail;
    int          errors = 0;
    int          checks = 0;

    // Model state, expressed over whole scans of key masks (index row*4+col).
    int          key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [15:0] hist [$];
    bit          armed;
    int          rel;
    bit          exp_acc;
    logic [3:0]  exp_code;
    logic [15:0] exp_value;

    keypad_hex_scanner #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .clr       (clr),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_down  (key_down),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Keypad switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && pressed[r*4+c]) row[r] = 1'b0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] key_mask(input int code);
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) if (key_tab[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int code_of(input logic [15:0] mask);
        int c = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) c = key_tab[i];
        return c;
    endfunction

    task automatic model_reset();
        hist.delete();
        armed     = 1'b1;
        rel       = 0;
        exp_code  = '0;
        exp_value = '0;
    endtask

    // Accept when armed and the last N scans saw the same single key; re-arm after N empty scans.
    task automatic model_scan(input logic [15:0] mask, input bit with_clr);
        bit same;
        hist.push_back(mask);
        exp_acc = 1'b0;
        if (armed) begin
            if (hist.size() >= N && $countones(mask) == 1) begin
                same = 1'b1;
                for (int j = 1; j <= N; j++)
                    if (hist[hist.size()-j] != mask) same = 1'b0;
                if (same) begin
                    exp_acc   = 1'b1;
                    armed     = 1'b0;
                    rel       = 0;
                    exp_code  = 4'(code_of(mask));
                    exp_value = {exp_value[11:0], exp_code};
                end
            end
        end else begin
            rel = (mask == '0) ? rel + 1 : 0;
            if (rel == N) armed = 1'b1;
        end
        if (with_clr) exp_value = '0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        clr      = 1'b0;
        clr_tail = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_col", 16'(col), 16'h000E);
        check("rst_key_valid", 16'(key_valid), 16'h0);
        check("rst_key_code", 16'(key_code), 16'h0);
        check("rst_key_down", 16'(key_down), 16'h0);
        check("rst_value", value, 16'h0);
    endtask

    task automatic run_scan(input logic [15:0] mask, input bit with_clr);
        pressed = mask;
        for (int i = 1; i <= SCANC; i++) begin
            clr = (i == SCANC && with_clr) || (i == 1 && clr_tail);
            @(posedge clk);
            #1;
            check("col", 16'(col), 16'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
            if (i < SCANC) check("key_valid_quiet", 16'(key_valid), 16'h0);
        end
        clr_tail = with_clr;
        model_scan(mask, with_clr);
        check("key_valid_scan_end", 16'(key_valid), 16'(exp_acc));
        check("key_code", 16'(key_code), 16'(exp_code));
        check("key_down", 16'(key_down), 16'(!armed));
        check("value", value, exp_value);
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        for (int s = 0; s < scans; s++) run_scan(mask, 1'b0);
    endtask

    initial begin
        logic [15:0] m;
        int          k;
        int          a;
        int          b;
        pressed = '0;
        rst     = 1'b1;
        clr     = 1'b0;
        do_reset();

        // Idle keypad: columns rotate, nothing accepted.
        hold('0, 7);

        // Key 5 held for six scans: one accept after the third.
        hold(key_mask(5), 6);
        check("plan_value_0005", value, 16'h0005);

        // Four digits push the leading 5 out.
        hold('0, 3);
        hold(key_mask(10), 4); hold('0, 4);
        hold(key_mask(3), 4);  hold('0, 4);
        hold(key_mask(15), 4); hold('0, 4);
        hold(key_mask(0), 4);  hold('0, 4);
        check("plan_value_A3F0", value, 16'hA3F0);

        // Bounce: the gap restarts the count.
        hold(key_mask(7), 2); hold('0, 1); hold(key_mask(7), 3);
        check("plan_code_7", 16'(key_code), 16'h7);
        hold('0, 4);

        // Ghosting: two keys together never accept; releasing one does.
        hold(key_mask(1) | key_mask(2), 5);
        hold(key_mask(1), 3);
        check("plan_code_1", 16'(key_code), 16'h1);
        hold('0, 4);

        // clr coincident with the accept of 9.
        hold(key_mask(9), 2);
        run_scan(key_mask(9), 1'b1);
        check("plan_clr_value", value, 16'h0);
        check("plan_clr_code", 16'(key_code), 16'h9);
        hold('0, 4);

        // Reset in the middle of debouncing B discards the progress.
        hold(key_mask(11), 2);
        do_reset();
        hold(key_mask(11), 3);
        check("plan_code_B", 16'(key_code), 16'hB);
        hold('0, 4);

        // Random segments of empty, ghosted and single-key scans.
        for (int seg = 0; seg < 30; seg++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            k = $urandom_range(0, 9);
            if (k < 2) begin
                m = '0;
            end else if (k < 4) begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                m = '0;
                m[a] = 1'b1;
                m[b] = 1'b1;
            end else begin
                m = key_mask(key_tab[$urandom_range(0, 15)]);
            end
            k = $urandom_range(1, 5);
            for (int s = 0; s < k; s++)
                run_scan(m, (s == k - 1) && ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
